result_drain: RTL and testbench
===============================

# result_drain

Write-back path for the systolic array, in the opposite direction to the input-side queue array. The block captures skewed per-lane result words from the array into small per-lane buffers, narrows each word from accumulator width to storage width, and serialises the tile into SRAM as lane-major writes. The controller starts the drain with a pulse and sees a sticky done flag.

## Interface
- `datawith`, default 16: SRAM word width, in bits.
- `acc_width`, default 32: width of each result lane from the array.
- `array_size`, default 2: number of lanes; each lane delivers `array_size` words per tile.
- `clk`, in, 1: clock. All logic is on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `write_start`, in, 1: one-cycle pulse that starts a drain. Sampled only in IDLE or DONE.
- `base_addr`, in, 10: first SRAM address. Latched when `write_start` is accepted.
- `result_valid`, in, `array_size`: per-lane push strobe.
- `result_data`, in, `array_size*acc_width`: lane k occupies bits `[k*acc_width +: acc_width]`.
- `sram_wr`, out, 1: SRAM write enable. Registered; reset value 0.
- `sram_addr`, out, 10: SRAM address. Registered; reset value 0.
- `sram_wdata`, out, `datawith`: SRAM write data. Registered; reset value 0.
- `busy`, out, 1: high in DRAIN and FLUSH. Reset value 0.
- `write_done`, out, 1: sticky; high in DONE. Reset value 0.
- `overflow_err`, out, 1: sticky lane-overflow flag. Cleared only by reset. Reset value 0.

## Operation
- **Lane buffers.** One first-word-fall-through FIFO per lane, depth `array_size`. Head data is valid whenever the FIFO is not empty.
  - Pushes are accepted in every state, including IDLE, so the array may finish before `write_start`.
  - Push to a full lane with no same-cycle pop: the word is dropped and `overflow_err` is set.
  - Push and pop on a full lane in the same cycle: both succeed; no error.
- **State machine:** IDLE, DRAIN, FLUSH, DONE.
  - IDLE or DONE, on `write_start`:
    - latch `base_addr`;
    - clear `lane_sel`, `idx` and `word_cnt`;
    - clear `write_done`;
    - go to DRAIN.
  - DRAIN, when FIFO[`lane_sel`] is not empty:
    - pop one word;
    - register `sram_wr`=1, `sram_addr` = `base + word_cnt` (10-bit, wraps modulo 1024), `sram_wdata` = narrowed head word;
    - increment `word_cnt` and `idx`;
    - when `idx` wraps at `array_size`, advance `lane_sel`.
  - DRAIN, when FIFO[`lane_sel`] is empty: stall with `sram_wr`=0. Other lanes are never popped out of order.
  - DRAIN, after the pop of word `array_size*array_size - 1`: go to FLUSH.
  - FLUSH: lasts one cycle, in which the last write is on the bus. Then go to DONE.
  - DONE: hold `write_done`=1 and `sram_wr`=0 until the next `write_start`.
  - `write_start` in DRAIN or FLUSH is ignored.
- **Narrowing:** the low `datawith` bits of the head word, unless saturation is compiled in (see Configuration).
- **Reset mid-drain:** all FIFOs empty, state IDLE, all outputs return to their reset values. Partially written SRAM contents are not repaired.

## Timing
- `write_start` sampled at edge T: DRAIN from T+1.
- With data already buffered, the first pop is at T+1 and `sram_wr` rises at T+2 with `sram_addr` = base.
- Throughput is 1 word/cycle while the current lane has data.
- Fully buffered tile of N = `array_size`² words: last write at T+N+1 (FLUSH), `write_done` rises at T+N+2.
- Push at cycle t: the word is poppable at t+1.
- `busy` and `write_done` are never high at the same time.

## Configuration
- `RESULT_DRAIN_SAT_EN` defined: each word is treated as signed and clamped to [-2^(`datawith`-1), 2^(`datawith`-1)-1] before being written.
- `RESULT_DRAIN_SAT_EN` undefined: plain truncation to the low `datawith` bits; no saturation logic is built.
- Timing and latency are identical in both builds.

## Structure
- Shared package holds:
  - the state enum (IDLE, DRAIN, FLUSH, DONE);
  - the SRAM address width constant (10);
  - a saturation function parameterised by input and output widths.
- One sub-module, `drain_lane_fifo`: FWFT FIFO parameterised by width and depth, with ports `push`, `pop`, `din`, `dout`, `empty`, `full`. It is instantiated `array_size` times from a generate loop.

## Test plan
All scenarios use `array_size`=2, `datawith`=16, `acc_width`=32.
1. **Buffered tile.** Push lane0 words 1, 2 and lane1 words 3, 4; then `write_start` with `base_addr`=0x100. Expect writes (0x100,1), (0x101,2), (0x102,3), (0x103,4) on four consecutive cycles, and `write_done` one cycle after the last write.
2. **Skewed arrival.** Start the drain first, then feed lane1 one cycle behind lane0, two cycles apart. Expect stalls (`sram_wr`=0) and lane-major order preserved.
3. **Overflow.** Push three words to lane0 with no pops. Expect `overflow_err`=1 and the third word dropped. A simultaneous push+pop on a full lane must leave `overflow_err`=0.
4. **Address wrap.** `base_addr`=0x3FE. Expect addresses 0x3FE, 0x3FF, 0x000, 0x001.
5. **Narrowing.**
   - Without `RESULT_DRAIN_SAT_EN`: 0x0001_2345 → 0x2345.
   - With it: 0x0001_2345 → 0x7FFF, 0xFFFE_0000 → 0x8000.
6. **Control hazards.**
   - Assert `rst_n` low mid-DRAIN: all outputs return to 0 and the FIFOs read empty.
   - `write_start` during DRAIN is ignored.
   - `write_start` in DONE clears `write_done` and starts a new drain.

Source files
------------

// File: rtl/result_drain_pkg.sv
// rtl/result_drain_pkg.sv - shared types, constants and saturation helper for result_drain
package result_drain_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DRAIN,
      ST_FLUSH,
      ST_DONE
   } state_e;

   localparam int ADDR_W    = 10;
   localparam int SAT_MAX_W = 64;

   // Signed clamp of an in_w-bit value into out_w bits; caller keeps the low out_w bits.
   function automatic logic [SAT_MAX_W-1:0] sat_narrow(input logic [SAT_MAX_W-1:0] din,
                                                       input int in_w,
                                                       input int out_w);
      logic signed [SAT_MAX_W-1:0] v;
      logic signed [SAT_MAX_W-1:0] hi;
      logic signed [SAT_MAX_W-1:0] lo;
      v  = $signed(din << (SAT_MAX_W - in_w)) >>> (SAT_MAX_W - in_w);
      hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (v > hi) begin
         return $unsigned(hi);
      end else if (v < lo) begin
         return $unsigned(lo);
      end
      return $unsigned(v);
   endfunction

endpackage

// File: rtl/drain_lane_fifo.sv
// rtl/drain_lane_fifo.sv - first-word-fall-through lane buffer for result_drain
module drain_lane_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push;
   logic             do_pop;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   assign empty   = (count_q == '0);
   assign full    = (count_q == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   // A full lane still accepts a word when its head leaves in the same cycle.
   assign do_push = push && (!full || do_pop);
   assign dout    = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q + CW'(do_push) - CW'(do_pop);
      if (do_push) begin
         wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

endmodule

// File: rtl/result_drain.sv
// rtl/result_drain.sv - systolic result write-back: lane FIFOs, narrowing, lane-major SRAM writes
// Optional saturation on narrowing when RESULT_DRAIN_SAT_EN is defined.
module result_drain
   import result_drain_pkg::*;
#(
   parameter int datawith   = 16,
   parameter int acc_width  = 32,
   parameter int array_size = 2
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           write_start,
   input  logic [ADDR_W-1:0]              base_addr,
   input  logic [array_size-1:0]          result_valid,
   input  logic [array_size*acc_width-1:0] result_data,
   output logic                           sram_wr,
   output logic [ADDR_W-1:0]              sram_addr,
   output logic [datawith-1:0]            sram_wdata,
   output logic                           busy,
   output logic                           write_done,
   output logic                           overflow_err
);

   localparam int N_WORDS = array_size * array_size;
   localparam int LW      = (array_size > 1) ? $clog2(array_size) : 1;
   localparam int CW      = $clog2(N_WORDS + 1);

   state_e               state_q, state_d;
   logic [LW-1:0]        lane_sel_q, lane_sel_d;
   logic [LW-1:0]        idx_q, idx_d;
   logic [CW-1:0]        word_cnt_q, word_cnt_d;
   logic [ADDR_W-1:0]    base_q, base_d;
   logic                 sram_wr_q, sram_wr_d;
   logic [ADDR_W-1:0]    sram_addr_q, sram_addr_d;
   logic [datawith-1:0]  sram_wdata_q, sram_wdata_d;
   logic                 overflow_q, overflow_d;

   logic [acc_width-1:0] lane_dout [array_size];
   logic [array_size-1:0] lane_empty;
   logic [array_size-1:0] lane_full;
   logic [array_size-1:0] lane_pop;
   logic [acc_width-1:0] head;
   logic [datawith-1:0]  narrowed;
   logic                 pop_any;

   for (genvar k = 0; k < array_size; k++) begin : g_lane
      // Only the selected lane may pop, which keeps the writes lane-major.
      assign lane_pop[k] = (state_q == ST_DRAIN) && (lane_sel_q == LW'(k)) && !lane_empty[k];

      drain_lane_fifo #(
         .WIDTH(acc_width),
         .DEPTH(array_size)
      ) u_fifo (
         .clk  (clk),
         .rst_n(rst_n),
         .push (result_valid[k]),
         .pop  (lane_pop[k]),
         .din  (result_data[k*acc_width +: acc_width]),
         .dout (lane_dout[k]),
         .empty(lane_empty[k]),
         .full (lane_full[k])
      );
   end

   assign head    = lane_dout[lane_sel_q];
   assign pop_any = |lane_pop;

`ifdef RESULT_DRAIN_SAT_EN
   assign narrowed = datawith'(sat_narrow(SAT_MAX_W'(head), acc_width, datawith));
`else
   assign narrowed = head[datawith-1:0];
`endif

   always_comb begin
      state_d      = state_q;
      lane_sel_d   = lane_sel_q;
      idx_d        = idx_q;
      word_cnt_d   = word_cnt_q;
      base_d       = base_q;
      sram_wr_d    = 1'b0;
      sram_addr_d  = sram_addr_q;
      sram_wdata_d = sram_wdata_q;
      overflow_d   = overflow_q | (|(result_valid & lane_full & ~lane_pop));

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (write_start) begin
               base_d     = base_addr;
               lane_sel_d = '0;
               idx_d      = '0;
               word_cnt_d = '0;
               state_d    = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (pop_any) begin
               sram_wr_d    = 1'b1;
               sram_addr_d  = base_q + ADDR_W'(word_cnt_q);
               sram_wdata_d = narrowed;
               word_cnt_d   = word_cnt_q + CW'(1);
               if (idx_q == LW'(array_size - 1)) begin
                  idx_d      = '0;
                  lane_sel_d = lane_sel_q + LW'(1);
               end else begin
                  idx_d = idx_q + LW'(1);
               end
               if (word_cnt_q == CW'(N_WORDS - 1)) begin
                  state_d = ST_FLUSH;
               end
            end
         end
         ST_FLUSH: state_d = ST_DONE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         lane_sel_q   <= '0;
         idx_q        <= '0;
         word_cnt_q   <= '0;
         base_q       <= '0;
         sram_wr_q    <= 1'b0;
         sram_addr_q  <= '0;
         sram_wdata_q <= '0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         lane_sel_q   <= lane_sel_d;
         idx_q        <= idx_d;
         word_cnt_q   <= word_cnt_d;
         base_q       <= base_d;
         sram_wr_q    <= sram_wr_d;
         sram_addr_q  <= sram_addr_d;
         sram_wdata_q <= sram_wdata_d;
         overflow_q   <= overflow_d;
      end
   end

   assign sram_wr      = sram_wr_q;
   assign sram_addr    = sram_addr_q;
   assign sram_wdata   = sram_wdata_q;
   assign overflow_err = overflow_q;
   assign busy         = (state_q == ST_DRAIN) || (state_q == ST_FLUSH);
   assign write_done   = (state_q == ST_DONE);

endmodule

// File: tb/tb_result_drain.sv
// tb/tb_result_drain.sv - scoreboard bench for result_drain (array_size=2, 16/32-bit words)
module tb_result_drain;

   logic        clk;
   logic        rst_n;
   logic        write_start;
   logic [9:0]  base_addr;
   logic [1:0]  result_valid;
   logic [63:0] result_data;
   logic        sram_wr;
   logic [9:0]  sram_addr;
   logic [15:0] sram_wdata;
   logic        busy;
   logic        write_done;
   logic        overflow_err;

   int checks;
   int failures;
   logic [25:0] exp_q[$];

   result_drain #(
      .datawith  (16),
      .acc_width (32),
      .array_size(2)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .write_start (write_start),
      .base_addr   (base_addr),
      .result_valid(result_valid),
      .result_data (result_data),
      .sram_wr     (sram_wr),
      .sram_addr   (sram_addr),
      .sram_wdata  (sram_wdata),
      .busy        (busy),
      .write_done  (write_done),
      .overflow_err(overflow_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic expect_wr(input logic [9:0] a, input logic [15:0] d);
      exp_q.push_back({a, d});
   endtask

   task automatic step(input logic [1:0] v, input logic [31:0] d0, input logic [31:0] d1,
                       input logic st, input logic [9:0] ba);
      result_valid = v;
      result_data  = {d1, d0};
      write_start  = st;
      base_addr    = ba;
      @(posedge clk);
      #1;
      result_valid = 2'b00;
      write_start  = 1'b0;
   endtask

   task automatic idle();
      step(2'b00, 32'h0, 32'h0, 1'b0, 10'h0);
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while (write_done !== 1'b1 && n < 40) begin
         idle();
         n++;
      end
      chk(name, {31'b0, write_done}, 32'd1);
      chk({name, "_sb_empty"}, exp_q.size(), 32'd0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_wr"},    {31'b0, sram_wr},      32'd0);
      chk({tag, "_addr"},  {22'b0, sram_addr},    32'd0);
      chk({tag, "_wdata"}, {16'b0, sram_wdata},   32'd0);
      chk({tag, "_busy"},  {31'b0, busy},         32'd0);
      chk({tag, "_done"},  {31'b0, write_done},   32'd0);
      chk({tag, "_ovf"},   {31'b0, overflow_err}, 32'd0);
   endtask

   // Monitor: every SRAM write must match the oldest expected write.
   always @(negedge clk) begin
      if (rst_n) begin
         if (busy && write_done) begin
            chk("busy_and_done", 32'd1, 32'd0);
         end
         if (sram_wr) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_write", {6'b0, sram_addr, sram_wdata}, 32'hFFFF_FFFF);
            end else begin
               chk("sram_write", {6'b0, sram_addr, sram_wdata}, {6'b0, exp_q.pop_front()});
            end
         end
      end
   end

   initial begin
      checks       = 0;
      failures     = 0;
      rst_n        = 1'b0;
      write_start  = 1'b0;
      base_addr    = 10'h0;
      result_valid = 2'b00;
      result_data  = 64'h0;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_outputs("reset");
      rst_n = 1'b1;

      // Buffered tile
      step(2'b11, 32'd1, 32'd3, 1'b0, 10'h0);
      step(2'b11, 32'd2, 32'd4, 1'b0, 10'h0);
      expect_wr(10'h100, 16'd1);
      expect_wr(10'h101, 16'd2);
      expect_wr(10'h102, 16'd3);
      expect_wr(10'h103, 16'd4);
      step(2'b00, 32'h0, 32'h0, 1'b1, 10'h100);
      chk("s1_busy", {31'b0, busy}, 32'd1);
      for (int i = 0; i < 4; i++) begin
         idle();
         chk("s1_back_to_back", {31'b0, sram_wr}, 32'd1);
      end
      chk("s1_flush_not_done", {31'b0, write_done}, 32'd0);
      idle();
      chk("s1_done", {31'b0, write_done}, 32'd1);
      chk("s1_wr_low", {31'b0, sram_wr}, 32'd0);
      chk("s1_sb_empty", exp_q.size(), 32'd0);

      // Skewed arrival, restart from DONE, start ignored in DRAIN
      expect_wr(10'h200, 16'h11);
      expect_wr(10'h201, 16'h12);
      expect_wr(10'h202, 16'h21);
      expect_wr(10'h203, 16'h22);
      step(2'b00, 32'h0, 32'h0, 1'b1, 10'h200);
      chk("s2_done_cleared", {31'b0, write_done}, 32'd0);
      chk("s2_busy", {31'b0, busy}, 32'd1);
      step(2'b01, 32'h11, 32'h0, 1'b0, 10'h0);
      chk("s2_stall", {31'b0, sram_wr}, 32'd0);
      step(2'b10, 32'h0, 32'h21, 1'b1, 10'h3AA);
      step(2'b01, 32'h12, 32'h0, 1'b0, 10'h0);
      chk("s2_stall2", {31'b0, sram_wr}, 32'd0);
      step(2'b10, 32'h0, 32'h22, 1'b0, 10'h0);
      wait_done("s2_done");

      // Overflow on lane0, third word dropped
      step(2'b01, 32'h31, 32'h0, 1'b0, 10'h0);
      step(2'b01, 32'h32, 32'h0, 1'b0, 10'h0);
      chk("s3_no_ovf_yet", {31'b0, overflow_err}, 32'd0);
      step(2'b01, 32'h33, 32'h0, 1'b0, 10'h0);
      chk("s3_ovf", {31'b0, overflow_err}, 32'd1);
      step(2'b10, 32'h0, 32'h41, 1'b0, 10'h0);
      step(2'b10, 32'h0, 32'h42, 1'b0, 10'h0);
      expect_wr(10'h000, 16'h31);
      expect_wr(10'h001, 16'h32);
      expect_wr(10'h002, 16'h41);
      expect_wr(10'h003, 16'h42);
      step(2'b00, 32'h0, 32'h0, 1'b1, 10'h000);
      wait_done("s3_done");
      chk("s3_ovf_sticky", {31'b0, overflow_err}, 32'd1);

      // Address wrap with push+pop on a full lane
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("s4_ovf_cleared", {31'b0, overflow_err}, 32'd0);
      step(2'b11, 32'h51, 32'h61, 1'b0, 10'h0);
      step(2'b11, 32'h52, 32'h62, 1'b0, 10'h0);
      expect_wr(10'h3FE, 16'h51);
      expect_wr(10'h3FF, 16'h52);
      expect_wr(10'h000, 16'h61);
      expect_wr(10'h001, 16'h62);
      step(2'b00, 32'h0, 32'h0, 1'b1, 10'h3FE);
      step(2'b01, 32'h53, 32'h0, 1'b0, 10'h0);
      chk("s4_pushpop_no_ovf", {31'b0, overflow_err}, 32'd0);
      wait_done("s4_done");

      // Reset mid-drain (lane0 still holds 0x53 from the previous push+pop)
      expect_wr(10'h050, 16'h53);
      step(2'b00, 32'h0, 32'h0, 1'b1, 10'h050);
      idle();
      step(2'b10, 32'h0, 32'h71, 1'b0, 10'h0);
      chk("s6_busy_before_reset", {31'b0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("s6_async_reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("s6_sb_empty", exp_q.size(), 32'd0);

      // FIFOs must be empty after reset: a fresh drain stalls until new data arrives
      step(2'b00, 32'h0, 32'h0, 1'b1, 10'h010);
      for (int i = 0; i < 3; i++) begin
         idle();
         chk("s6_empty_stall", {31'b0, sram_wr}, 32'd0);
      end
      chk("s6_still_busy", {31'b0, busy}, 32'd1);

      // Narrowing
`ifdef RESULT_DRAIN_SAT_EN
      expect_wr(10'h010, 16'h7FFF);
      expect_wr(10'h011, 16'h8000);
      expect_wr(10'h012, 16'h7FFF);
      expect_wr(10'h013, 16'h8000);
`else
      expect_wr(10'h010, 16'h2345);
      expect_wr(10'h011, 16'h0000);
      expect_wr(10'h012, 16'hFFFF);
      expect_wr(10'h013, 16'h8000);
`endif
      step(2'b11, 32'h0001_2345, 32'h0000_FFFF, 1'b0, 10'h0);
      step(2'b11, 32'hFFFE_0000, 32'hFFFF_8000, 1'b0, 10'h0);
      wait_done("s5_done");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
